// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier: FSM encoding and tile geometry.
package vedic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int TILE_W   = 2;
   localparam int TILE_P_W = 4;

endpackage

// File: rtl/vedic_mul_seq_ctrl_if.sv
// Operand/result handshake bundle for vedic_mul_seq_ctrl.
interface vedic_mul_seq_ctrl_if #(
   parameter int WIDTH = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/vedic_tile2x2.sv
// Combinational 2x2 Vedic (Urdhva Tiryagbhyam) tile built from two half adders.
module vedic_tile2x2
   import vedic_pkg::*;
(
   input  logic [TILE_W-1:0]   x,
   input  logic [TILE_W-1:0]   y,
   output logic [TILE_P_W-1:0] p
);
   logic cross_hi;
   logic cross_lo;
   logic vert_hi;
   logic s1;
   logic c1;
   logic s2;
   logic c2;

   assign cross_hi = x[1] & y[0];
   assign cross_lo = x[0] & y[1];
   assign vert_hi  = x[1] & y[1];

   // First half adder sums the crosswise terms, second folds its carry into the top term.
   assign s1 = cross_hi ^ cross_lo;
   assign c1 = cross_hi & cross_lo;
   assign s2 = vert_hi ^ c1;
   assign c2 = vert_hi & c1;

   assign p = {c2, s2, s1, x[0] & y[0]};
endmodule

// File: rtl/vedic_mul_seq_ctrl.sv
// Sequential WIDTH x WIDTH multiplier time-sharing one 2x2 Vedic tile.
// Optional VEDIC_SEQ_ZERO_SKIP_EN: a zero operand finishes after one cycle without tile passes.
module vedic_mul_seq_ctrl
   import vedic_pkg::*;
#(
   parameter int WIDTH = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   vedic_mul_seq_ctrl_if.slave   bus
);
   localparam int HALF  = WIDTH / 2;
   localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int PW    = 2 * WIDTH;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(HALF - 1);

   state_t               state_q;
   state_t               state_d;
   logic [IDX_W-1:0]     i_q;
   logic [IDX_W-1:0]     j_q;
   logic [WIDTH-1:0]     a_lat;
   logic [WIDTH-1:0]     b_lat;
   logic [PW-1:0]        acc_q;
   logic [TILE_P_W-1:0]  tile_p;
   logic [PW-1:0]        term;
   logic                 accept;
   logic                 in_ready;
   logic                 out_valid;
   logic                 busy;
   logic                 skip;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
   logic                 zero_q;
`endif

   vedic_tile2x2 u_tile (
      .x (a_lat[2*i_q +: TILE_W]),
      .y (b_lat[2*j_q +: TILE_W]),
      .p (tile_p)
   );

   assign term = PW'(tile_p) << (2 * (int'(i_q) + int'(j_q)));

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
   assign skip = zero_q;
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (skip || (i_q == LAST && j_q == LAST)) state_d = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
         end else if (state_q == ST_RUN && !skip) begin
            // Slice pairs walk j fastest; the add can never carry out of 2*WIDTH bits.
            acc_q <= acc_q + term;
            if (j_q == LAST) begin
               j_q <= '0;
               i_q <= i_q + IDX_W'(1);
            end else begin
               j_q <= j_q + IDX_W'(1);
            end
         end
      end
   end

   // Operand latches only matter from the accept edge onward, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_lat <= bus.a;
         b_lat <= bus.b;
      end
   end

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
   always_ff @(posedge clk) begin
      if (rst)         zero_q <= 1'b0;
      else if (accept) zero_q <= (bus.a == '0) || (bus.b == '0);
   end
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.product   = acc_q;
endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Directed self-checking bench for vedic_mul_seq_ctrl (WIDTH=4).
module tb_vedic_mul_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   vedic_mul_seq_ctrl_if #(.WIDTH(4)) bus ();

   vedic_mul_seq_ctrl #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 4;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one operation from IDLE, returning latency and product; consumes the result.
   task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                         output int lat, output logic [7:0] p);
      bus.in_valid  = 1'b1;
      bus.a         = av;
      bus.b         = bv;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = ~av;
      bus.b        = ~bv;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         tick();
         lat++;
      end
      p = bus.product;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.product !== 8'h00) begin
         fails++;
         $display("FAIL reset: in_ready=%b out_valid=%b busy=%b product=%h, need 1 0 0 00",
                  bus.in_ready, bus.out_valid, bus.busy, bus.product);
      end
   endtask

   task automatic test_basic();
      int lat;
      int run_bad;
      bus.in_valid  = 1'b1;
      bus.a         = 4'd3;
      bus.b         = 4'd5;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      run_bad = 0;
      while (!bus.out_valid && lat < 50) begin
         if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) run_bad++;
         tick();
         lat++;
      end
      tests++;
      if (run_bad != 0) begin
         fails++;
         $display("FAIL basic_run_ready: %0d RUN cycles with in_ready=1 or busy=0, need 0", run_bad);
      end
      tests++;
      if (lat != 4) begin
         fails++;
         $display("FAIL basic_latency: got %0d cycles, need 4", lat);
      end
      tests++;
      if (bus.product !== 8'h0F) begin
         fails++;
         $display("FAIL basic_product: got %h, need 0f", bus.product);
      end
      tick();
      bus.out_ready = 1'b0;
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_return_idle: in_ready=%b out_valid=%b, need 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_max();
      int lat;
      logic [7:0] p;
      run_op(4'hF, 4'hF, lat, p);
      tests++;
      if (p !== 8'hE1 || lat != 4) begin
         fails++;
         $display("FAIL max_operands: got %h lat %0d, need e1 lat 4", p, lat);
      end
   endtask

   task automatic test_sweep();
      int lat;
      logic [7:0] p;
      logic [7:0] exp;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            exp = 8'(x * y);
            run_op(4'(x), 4'(y), lat, p);
            tests++;
            if (p !== exp) begin
               fails++;
               $display("FAIL sweep_%0dx%0d: got %h, need %h", x, y, p, exp);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bus.in_valid  = 1'b1;
      bus.a         = 4'd9;
      bus.b         = 4'd7;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         tick();
         lat++;
      end
      for (int k = 0; k < 5; k++) begin
         tests++;
         if (bus.out_valid !== 1'b1 || bus.product !== 8'h3F) begin
            fails++;
            $display("FAIL hold_cycle%0d: out_valid=%b product=%h, need 1 3f", k, bus.out_valid, bus.product);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b, need 1 0 0",
                  bus.in_ready, bus.out_valid, bus.busy);
      end
   endtask

   task automatic test_abort();
      int lat;
      logic [7:0] p;
      bus.in_valid  = 1'b1;
      bus.a         = 4'd6;
      bus.b         = 4'd6;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_state: in_ready=%b out_valid=%b busy=%b, need 1 0 0",
                  bus.in_ready, bus.out_valid, bus.busy);
      end
      run_op(4'd2, 4'd3, lat, p);
      tests++;
      if (p !== 8'h06 || lat != 4) begin
         fails++;
         $display("FAIL abort_next_op: got %h lat %0d, need 06 lat 4", p, lat);
      end
   endtask

   task automatic test_zero();
      int lat;
      logic [7:0] p;
      run_op(4'd0, 4'd11, lat, p);
      tests++;
      if (p !== 8'h00 || lat != ZERO_LAT) begin
         fails++;
         $display("FAIL zero_a: got %h lat %0d, need 00 lat %0d", p, lat, ZERO_LAT);
      end
      run_op(4'd11, 4'd0, lat, p);
      tests++;
      if (p !== 8'h00 || lat != ZERO_LAT) begin
         fails++;
         $display("FAIL zero_b: got %h lat %0d, need 00 lat %0d", p, lat, ZERO_LAT);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int n;
      int t[2];
      logic [7:0] p[2];
      t[0] = -1; t[1] = -1;
      p[0] = 8'hXX; p[1] = 8'hXX;
      bus.in_valid  = 1'b1;
      bus.a         = 4'd3;
      bus.b         = 4'd4;
      bus.out_ready = 1'b1;
      tick();
      bus.a = 4'd5;
      bus.b = 4'd5;
      cyc = 0;
      n = 0;
      while (n < 2 && cyc < 40) begin
         tick();
         cyc++;
         if (bus.out_valid) begin
            t[n] = cyc;
            p[n] = bus.product;
            n++;
            if (n == 2) bus.in_valid = 1'b0;
         end
      end
      tick();
      bus.out_ready = 1'b0;
      tests++;
      if (n != 2) begin
         fails++;
         $display("FAIL b2b_count: got %0d results, need 2", n);
      end
      tests++;
      if (p[0] !== 8'h0C || p[1] !== 8'h19) begin
         fails++;
         $display("FAIL b2b_products: got %h %h, need 0c 19", p[0], p[1]);
      end
      tests++;
      if (t[0] != 4 || t[1] - t[0] != 6) begin
         fails++;
         $display("FAIL b2b_timing: got first at %0d spacing %0d, need 4 and 6", t[0], t[1] - t[0]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = 4'd0;
      bus.b         = 4'd0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_abort();
      test_zero();
      test_back_to_back();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
